// File: rtl/read_return_reorder.sv
// rtl/read_return_reorder.sv - in-order read return buffer with index pool and write-ack passthrough
// Optional feature macro RETURN_BYPASS_EN: zero-latency release of a head entry filled this cycle.
module read_return_reorder #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              in_valid,
  input  logic              in_type,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              wr_ack,
  output logic [IDX_W-1:0]  wr_ack_index,
  output logic [IDX_W:0]    occupancy,
  output logic              err_unalloc,
  output logic              err_dup
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};
  localparam logic R_TYPE_WRITE = 1'b1;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ack_q, wr_ack_d;
  logic [IDX_W-1:0]  wr_ack_index_q, wr_ack_index_d;
  logic              err_unalloc_q, err_unalloc_d;
  logic              err_dup_q, err_dup_d;

  logic [IDX_W-1:0]  head_idx;
  logic [IDX_W-1:0]  tail_idx;
  logic [IDX_W-1:0]  fill_off;
  logic [PTR_W-1:0]  occ;
  logic              empty;
  logic              full;
  logic              fill_rd;
  logic              fill_alloc;
  logic              fill_ok;
  logic              head_done;
  logic              rel_fire;
  logic              mem_we;

  // Pool bookkeeping; an index is live iff its distance from head is below occupancy.
  always_comb begin
    head_idx   = head_q[IDX_W-1:0];
    tail_idx   = tail_q[IDX_W-1:0];
    occ        = tail_q - head_q;
    empty      = (head_q == tail_q);
    full       = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    fill_rd    = in_valid && (in_type != R_TYPE_WRITE);
    fill_off   = in_index - head_idx;
    fill_alloc = ({1'b0, fill_off} < occ);
    fill_ok    = fill_rd && fill_alloc && !done_q[in_index];
    head_done  = !empty && done_q[head_idx];
  end

`ifdef RETURN_BYPASS_EN
  logic bypass;

  // A fresh fill to the waiting head is forwarded straight out; it is only stored if refused.
  always_comb begin
    bypass    = fill_ok && (fill_off == '0);
    out_valid = head_done || bypass;
    out_data  = bypass ? in_data : mem_q[head_idx];
    rel_fire  = out_valid && out_ready;
    mem_we    = fill_ok && !(bypass && out_ready);
  end
`else
  always_comb begin
    out_valid = head_done;
    out_data  = mem_q[head_idx];
    rel_fire  = out_valid && out_ready;
    mem_we    = fill_ok;
  end
`endif

  always_comb begin
    alloc_gnt    = alloc_req && !full;
    alloc_idx    = tail_idx;
    out_index    = head_idx;
    occupancy    = occ;
    wr_ack       = wr_ack_q;
    wr_ack_index = wr_ack_index_q;
    err_unalloc  = err_unalloc_q;
    err_dup      = err_dup_q;
  end

  // Release clears the head bit before a fill may set another bit in the same cycle.
  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    done_d         = done_q;
    err_unalloc_d  = err_unalloc_q;
    err_dup_d      = err_dup_q;
    wr_ack_d       = in_valid && (in_type == R_TYPE_WRITE);
    wr_ack_index_d = wr_ack_index_q;
    if (rel_fire) begin
      done_d[head_idx] = 1'b0;
      head_d           = head_q + PTR_ONE;
    end
    if (mem_we) begin
      done_d[in_index] = 1'b1;
    end
    if (alloc_gnt) begin
      tail_d = tail_q + PTR_ONE;
    end
    if (fill_rd && !fill_alloc) begin
      err_unalloc_d = 1'b1;
    end
    if (fill_rd && fill_alloc && done_q[in_index]) begin
      err_dup_d = 1'b1;
    end
    if (wr_ack_d) begin
      wr_ack_index_d = in_index;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      done_q         <= '0;
      wr_ack_q       <= 1'b0;
      wr_ack_index_q <= '0;
      err_unalloc_q  <= 1'b0;
      err_dup_q      <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      done_q         <= done_d;
      wr_ack_q       <= wr_ack_d;
      wr_ack_index_q <= wr_ack_index_d;
      err_unalloc_q  <= err_unalloc_d;
      err_dup_q      <= err_dup_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[in_index] <= in_data;
    end
  end

endmodule
